// File: rtl/uart_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_cfg_pkg : register map, FSM encodings and step-table entry layout     |
// |                shared by uart_cfg_seq and uart_bus_access.                 |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package uart_cfg_pkg;

  localparam logic [2:0] REG_RBR = 3'd0;
  localparam logic [2:0] REG_THR = 3'd0;
  localparam logic [2:0] REG_DLL = 3'd0;
  localparam logic [2:0] REG_IER = 3'd1;
  localparam logic [2:0] REG_DLM = 3'd1;
  localparam logic [2:0] REG_FCR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_MCR = 3'd4;
  localparam logic [2:0] REG_LSR = 3'd5;
  localparam logic [2:0] REG_MSR = 3'd6;
  localparam logic [2:0] REG_SCR = 3'd7;

  localparam logic [7:0] LCR_DLAB = 8'h80;

  // Bits that survive a readback of each register on a 16550/16750
  localparam logic [7:0] LCR_RB_MASK = 8'h7F;
  localparam logic [7:0] MCR_RB_MASK = 8'h1F;
  localparam logic [7:0] IER_RB_MASK = 8'h0F;

  typedef enum logic [1:0] {
    ACC_IDLE   = 2'd0,
    ACC_SETUP  = 2'd1,
    ACC_STROBE = 2'd2,
    ACC_HOLD   = 2'd3
  } acc_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic       rd;
    logic [2:0] addr;
    logic [7:0] data;
  } step_t;

  function automatic step_t mk_step(input logic rd, input logic [2:0] addr,
                                    input logic [7:0] data);
    step_t s;
    s.rd   = rd;
    s.addr = addr;
    s.data = data;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cfg_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_cfg_seq_if : cs/wr/rd/a/din/dout register bus towards uart_16750.     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
interface uart_cfg_seq_if;
  logic       uart_cs;
  logic       uart_wr;
  logic       uart_rd;
  logic [2:0] uart_a;
  logic [7:0] uart_dout;
  logic [7:0] uart_din;

  modport master (
    output uart_cs, uart_wr, uart_rd, uart_a, uart_dout,
    input  uart_din
  );

  modport slave (
    input  uart_cs, uart_wr, uart_rd, uart_a, uart_dout,
    output uart_din
  );
endinterface
`default_nettype wire

// File: rtl/uart_bus_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_bus_access : one SETUP/STROBE/HOLD register access per request;       |
// |                   captures read data when UART_CFG_READBACK_EN is defined. |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module uart_bus_access
  import uart_cfg_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_i,
  input  logic           rd_nwr_i,
  input  logic [2:0]     addr_i,
  input  logic [7:0]     data_i,
  output logic           hold_o,
`ifdef UART_CFG_READBACK_EN
  output logic [7:0]     rdata_o,
`endif
  uart_cfg_seq_if.master bus
);

  localparam logic [3:0] C_SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] C_STROBE_LAST = 4'(STROBE_CYCLES - 1);

  acc_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rd_nwr_q, rd_nwr_d;
  logic [2:0] a_q, a_d;
  logic [7:0] dout_q, dout_d;
  logic       cs_q;
  logic       wr_q;

  // A request is taken in IDLE or in HOLD, so back-to-back accesses add no gap
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_nwr_d = rd_nwr_q;
    a_d      = a_q;
    dout_d   = dout_q;
    case (state_q)
      ACC_IDLE, ACC_HOLD: begin
        if (req_i) begin
          state_d  = ACC_SETUP;
          cnt_d    = C_SETUP_LAST;
          rd_nwr_d = rd_nwr_i;
          a_d      = addr_i;
          if (!rd_nwr_i) dout_d = data_i;
        end else if (state_q == ACC_HOLD) begin
          state_d = ACC_IDLE;
        end
      end
      ACC_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ACC_STROBE;
          cnt_d   = C_STROBE_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACC_STROBE: begin
        if (cnt_q == '0) state_d = ACC_HOLD;
        else             cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACC_IDLE;
      cnt_q    <= '0;
      rd_nwr_q <= 1'b0;
      a_q      <= '0;
      dout_q   <= '0;
      cs_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_nwr_q <= rd_nwr_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      cs_q     <= (state_d == ACC_SETUP) || (state_d == ACC_STROBE);
      wr_q     <= (state_d == ACC_STROBE) && !rd_nwr_d;
    end
  end

`ifdef UART_CFG_READBACK_EN
  logic       rd_q;
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      rd_q <= (state_d == ACC_STROBE) && rd_nwr_d;
      if (state_q == ACC_STROBE && cnt_q == '0) rdata_q <= bus.uart_din;
    end
  end

  assign bus.uart_rd = rd_q;
  assign rdata_o     = rdata_q;
`else
  assign bus.uart_rd = 1'b0;
`endif

  assign bus.uart_cs   = cs_q;
  assign bus.uart_wr   = wr_q;
  assign bus.uart_a    = a_q;
  assign bus.uart_dout = dout_q;
  assign hold_o        = (state_q == ACC_HOLD);

endmodule
`default_nettype wire

// File: rtl/uart_cfg_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_cfg_seq : power-up / reconfiguration write program for a 16550/16750. |
// |                Define UART_CFG_READBACK_EN to append LCR/MCR/IER readback. |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module uart_cfg_seq
  import uart_cfg_pkg::*;
#(
  parameter logic [15:0] DIVISOR       = 16'd17,
  parameter logic [7:0]  LCR_VAL       = 8'h03,
  parameter logic [7:0]  FCR_VAL       = 8'h81,
  parameter logic [7:0]  MCR_VAL       = 8'h00,
  parameter logic [7:0]  IER_VAL       = 8'h01,
  parameter int          SETUP_CYCLES  = 1,
  parameter int          STROBE_CYCLES = 1,
  parameter bit          AUTO_START    = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           err,
  uart_cfg_seq_if.master bus
);

`ifdef UART_CFG_READBACK_EN
  localparam logic [3:0] C_LAST_STEP = 4'd9;
`else
  localparam logic [3:0] C_LAST_STEP = 4'd6;
`endif

  seq_state_e state_q, state_d;
  logic [3:0] step_q, step_d;
  logic       auto_q, auto_d;
  logic       busy_q;
  logic       done_q;
  logic       go;
  logic       req;
  logic       acc_hold;
  step_t      req_entry;

  // For reads the data field carries the expected readback value
  function automatic step_t step_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    return mk_step(1'b0, REG_LCR, LCR_VAL | LCR_DLAB);
      4'd1:    return mk_step(1'b0, REG_DLL, DIVISOR[7:0]);
      4'd2:    return mk_step(1'b0, REG_DLM, DIVISOR[15:8]);
      4'd3:    return mk_step(1'b0, REG_LCR, LCR_VAL & ~LCR_DLAB);
      4'd4:    return mk_step(1'b0, REG_FCR, FCR_VAL);
      4'd5:    return mk_step(1'b0, REG_MCR, MCR_VAL);
      4'd6:    return mk_step(1'b0, REG_IER, IER_VAL);
`ifdef UART_CFG_READBACK_EN
      4'd7:    return mk_step(1'b1, REG_LCR, LCR_VAL & LCR_RB_MASK);
      4'd8:    return mk_step(1'b1, REG_MCR, MCR_VAL & MCR_RB_MASK);
      4'd9:    return mk_step(1'b1, REG_IER, IER_VAL & IER_RB_MASK);
`endif
      default: return mk_step(1'b0, REG_IER, IER_VAL);
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    auto_d  = auto_q;
    req     = 1'b0;
    go      = 1'b0;
    case (state_q)
      SEQ_IDLE: go = start || auto_q;
      SEQ_DONE: go = start;
      SEQ_RUN: begin
        if (acc_hold) begin
          if (step_q == C_LAST_STEP) begin
            state_d = SEQ_DONE;
          end else begin
            req    = 1'b1;
            step_d = step_q + 4'd1;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    if (go) begin
      req     = 1'b1;
      step_d  = '0;
      state_d = SEQ_RUN;
      auto_d  = 1'b0;
    end
  end

  assign req_entry = step_entry(step_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      step_q  <= '0;
      auto_q  <= AUTO_START;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      auto_q  <= auto_d;
      busy_q  <= (state_d == SEQ_RUN);
      done_q  <= (state_d == SEQ_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;

`ifdef UART_CFG_READBACK_EN
  logic [7:0] rdata;
  logic       err_q, err_d;
  step_t      cur_entry;

  assign cur_entry = step_entry(step_q);

  // Captured read data is valid during the HOLD cycle of a read step
  always_comb begin
    err_d = err_q;
    if (go) begin
      err_d = 1'b0;
    end else if (state_q == SEQ_RUN && acc_hold && cur_entry.rd &&
                 rdata != cur_entry.data) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  uart_bus_access #(
    .SETUP_CYCLES  (SETUP_CYCLES),
    .STROBE_CYCLES (STROBE_CYCLES)
  ) u_access (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .rd_nwr_i (req_entry.rd),
    .addr_i   (req_entry.addr),
    .data_i   (req_entry.data),
    .hold_o   (acc_hold),
`ifdef UART_CFG_READBACK_EN
    .rdata_o  (rdata),
`endif
    .bus      (bus)
  );

endmodule
`default_nettype wire
